// File: rtl/adc_dout_capture.sv
// Captures the 12-bit X then Y results from the ADC serial DOUT line within each 80-count frame; ADC_DOUT_PENIRQ_EN adds pen-up gating.
// Latency: X_DATA/Y_DATA/DATA_VALID update on the edge of the FRAME_LAST count event.
// Backpressure: none; the ADC paces the frame, DATA_VALID is a one-cycle pulse.
module adc_dout_capture #(
    parameter int X_SAMPLE0  = 19,
    parameter int Y_SAMPLE0  = 51,
    parameter int FRAME_LAST = 79
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        Enable,
    input  logic [6:0]  Cuenta,
    input  logic        ADC_DOUT,
`ifdef ADC_DOUT_PENIRQ_EN
    input  logic        ADC_PENIRQ_n,
`endif
    output logic [11:0] X_DATA,
    output logic [11:0] Y_DATA,
    output logic        DATA_VALID,
    output logic        BUSY
);
    typedef enum logic [1:0] {IDLE, CAP_X, CAP_Y, DONE} state_t;

    // Twelve samples, one per DCLK period (two counts), so the last lands 22 counts after the first.
    localparam logic [6:0] SPAN = 7'd22;

    state_t      state, state_nxt;
    logic [6:0]  cuenta_q;
    logic [11:0] x_sh, y_sh;
    logic        count_evt, frame_start;
    logic [6:0]  x_off, y_off;
    logic        x_hit, y_hit;
    logic [3:0]  x_pos, y_pos;
    logic        clr_sh, x_wr, y_wr, commit, pen_ok;

    assign count_evt   = Enable && (Cuenta != cuenta_q) && (Cuenta <= 7'(FRAME_LAST));
    assign frame_start = count_evt && (Cuenta == 7'd0);

    assign x_off = Cuenta - 7'(X_SAMPLE0);
    assign y_off = Cuenta - 7'(Y_SAMPLE0);
    assign x_hit = (Cuenta >= 7'(X_SAMPLE0)) && (x_off <= SPAN) && !x_off[0];
    assign y_hit = (Cuenta >= 7'(Y_SAMPLE0)) && (y_off <= SPAN) && !y_off[0];
    assign x_pos = 4'd11 - x_off[4:1];
    assign y_pos = 4'd11 - y_off[4:1];

`ifdef ADC_DOUT_PENIRQ_EN
    // Pen state is latched at frame start; a pen-up frame is still walked but never published.
    logic pen_up;
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            pen_up <= 1'b0;
        else if (frame_start)
            pen_up <= ADC_PENIRQ_n;
    end
    assign pen_ok = !pen_up;
`else
    assign pen_ok = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_sh    = 1'b0;
        x_wr      = 1'b0;
        y_wr      = 1'b0;
        commit    = 1'b0;
        if (!Enable) begin
            state_nxt = IDLE;
            clr_sh    = 1'b1;
        end else if (frame_start) begin
            state_nxt = CAP_X;
            clr_sh    = 1'b1;
        end else if (count_evt) begin
            case (state)
                CAP_X: if (x_hit) begin
                    x_wr = 1'b1;
                    if (x_off == SPAN)
                        state_nxt = CAP_Y;
                end
                CAP_Y: if (y_hit) begin
                    y_wr = 1'b1;
                    if (y_off == SPAN)
                        state_nxt = DONE;
                end
                DONE: if (Cuenta == 7'(FRAME_LAST)) begin
                    commit    = pen_ok;
                    state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cuenta_q   <= 7'h7F;
            x_sh       <= '0;
            y_sh       <= '0;
            X_DATA     <= '0;
            Y_DATA     <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            cuenta_q   <= Cuenta;
            DATA_VALID <= commit;
            if (clr_sh) begin
                x_sh <= '0;
                y_sh <= '0;
            end
            if (x_wr)
                x_sh[x_pos] <= ADC_DOUT;
            if (y_wr)
                y_sh[y_pos] <= ADC_DOUT;
            if (commit) begin
                X_DATA <= x_sh;
                Y_DATA <= y_sh;
            end
        end
    end

    assign BUSY = (state == CAP_X) || (state == CAP_Y);

endmodule

// File: tb/tb_adc_dout_capture.sv
// Randomized frame stimulus checked every cycle against a frame-level model, plus literal pins for the directed scenarios.
module tb_adc_dout_capture;
    localparam int XS = 19;
    localparam int YS = 51;
    localparam int FL = 79;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b1;
    logic        Enable = 1'b0;
    logic        ADC_DOUT = 1'b0;
    logic        pen_n = 1'b0;
    logic [6:0]  Cuenta = 7'd0;
    logic [11:0] X_DATA, Y_DATA;
    logic        DATA_VALID, BUSY;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int dv_last_ev = 0;
    int dv_prev_ev = 0;
    bit cmp_en = 1'b0;

    adc_dout_capture dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .Enable(Enable),
        .Cuenta(Cuenta),
        .ADC_DOUT(ADC_DOUT),
`ifdef ADC_DOUT_PENIRQ_EN
        .ADC_PENIRQ_n(pen_n),
`endif
        .X_DATA(X_DATA),
        .Y_DATA(Y_DATA),
        .DATA_VALID(DATA_VALID),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: remembers the last DOUT seen on each count of the current frame.
    logic [6:0]  m_prev;
    logic [79:0] m_seen, m_samp;
    logic        m_started, m_pen, m_valid;
    logic [11:0] m_x, m_y;
    int          m_evcnt = 0;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_prev = 7'h7F; m_seen = '0; m_samp = '0;
            m_started = 1'b0; m_pen = 1'b0; m_valid = 1'b0;
            m_x = '0; m_y = '0;
        end else begin
            m_valid = 1'b0;
            if (!Enable) begin
                m_started = 1'b0;
            end else if (Cuenta != m_prev && int'(Cuenta) <= FL) begin
                m_evcnt++;
                if (Cuenta == 7'd0) begin
                    m_started = 1'b1; m_seen = '0; m_samp = '0;
`ifdef ADC_DOUT_PENIRQ_EN
                    m_pen = pen_n;
`endif
                end else if (m_started) begin
                    m_samp[Cuenta] = ADC_DOUT;
                    m_seen[Cuenta] = 1'b1;
                    if (int'(Cuenta) == FL && m_seen[YS+22]) begin
                        m_started = 1'b0;
                        if (!m_pen) begin
                            for (int i = 0; i < 12; i++) begin
                                m_x[11-i] = m_samp[XS+2*i];
                                m_y[11-i] = m_samp[YS+2*i];
                            end
                            m_valid = 1'b1;
                        end
                    end
                end
            end
            m_prev = Cuenta;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("x_data", X_DATA, m_x);
            chk("y_data", Y_DATA, m_y);
            chk("data_valid", {11'b0, DATA_VALID}, {11'b0, m_valid});
            chk("busy", {11'b0, BUSY}, {11'b0, m_started && !m_seen[YS+22]});
            if (DATA_VALID) begin
                dv_cnt++;
                dv_prev_ev = dv_last_ev;
                dv_last_ev = m_evcnt;
            end
        end
    end

    function automatic logic dout_for(input int c, input logic [11:0] x, input logic [11:0] y);
        if (c >= XS && c <= XS + 22 && (c - XS) % 2 == 0) return x[11-(c-XS)/2];
        if (c >= YS && c <= YS + 22 && (c - YS) % 2 == 0) return y[11-(c-YS)/2];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic frame(input logic [11:0] x, input logic [11:0] y, input int hold,
                         input int abort_at, input int rst_at,
                         input bit skip_last, input bit garbage, input bit pen);
        for (int c = 0; c <= FL; c++) begin
            if (c == FL && skip_last) break;
            for (int h = 0; h < hold; h++) begin
                @(posedge CLK); #2;
                RST_n = 1'b1; Enable = 1'b1; Cuenta = 7'(c); pen_n = pen;
                ADC_DOUT = (h == 0) ? dout_for(c, x, y) : 1'($urandom_range(0, 1));
                if (c == abort_at && h == 0) begin
                    repeat (3) begin @(posedge CLK); #2; Enable = 1'b0; end
                    return;
                end
                if (c == rst_at && h == 0) begin
                    RST_n = 1'b0; #1;
                    chk("rst_x_zero", X_DATA, 12'h000);
                    chk("rst_y_zero", Y_DATA, 12'h000);
                    chk("rst_busy_low", {11'b0, BUSY}, 12'h000);
                    chk("rst_valid_low", {11'b0, DATA_VALID}, 12'h000);
                end
            end
            if (garbage && c < FL && $urandom_range(0, 3) == 0) begin
                @(posedge CLK); #2;
                Cuenta = 7'($urandom_range(80, 127));
                ADC_DOUT = 1'($urandom_range(0, 1));
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int dv0;
        #1 RST_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_x", X_DATA, 12'h000);
        chk("reset_y", Y_DATA, 12'h000);
        chk("reset_valid", {11'b0, DATA_VALID}, 12'h000);
        chk("reset_busy", {11'b0, BUSY}, 12'h000);

        frame(12'hA5C, 12'h3F1, 2, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("basic_x", X_DATA, 12'hA5C);
        chk("basic_y", Y_DATA, 12'h3F1);
        chk("basic_pulses", 12'(dv_cnt), 12'd1);

        frame(12'h5A3, 12'h0C7, 2, 30, -1, 1'b0, 1'b0, 1'b0);
        chk("abort_x_held", X_DATA, 12'hA5C);
        chk("abort_y_held", Y_DATA, 12'h3F1);
        chk("abort_no_pulse", 12'(dv_cnt), 12'd1);
        frame(12'h5A3, 12'h0C7, 2, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("restart_x", X_DATA, 12'h5A3);
        chk("restart_y", Y_DATA, 12'h0C7);

        frame(12'h6B9, 12'h94E, 5, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("hold5_x", X_DATA, 12'h6B9);
        chk("hold5_y", Y_DATA, 12'h94E);

        frame(12'h777, 12'h888, 2, -1, 60, 1'b0, 1'b0, 1'b0);
        chk("midreset_no_capture", X_DATA, 12'h000);
        frame(12'h3C3, 12'h1E1, 2, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("post_reset_x", X_DATA, 12'h3C3);
        chk("post_reset_y", Y_DATA, 12'h1E1);

        dv0 = dv_cnt;
        frame(12'hFFF, 12'h000, 2, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("b2b1_x", X_DATA, 12'hFFF);
        chk("b2b1_y", Y_DATA, 12'h000);
        frame(12'h000, 12'hFFF, 2, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("b2b2_x", X_DATA, 12'h000);
        chk("b2b2_y", Y_DATA, 12'hFFF);
        chk("b2b_pulses", 12'(dv_cnt - dv0), 12'd2);
        chk("b2b_spacing", 12'(dv_last_ev - dv_prev_ev), 12'd80);

`ifdef ADC_DOUT_PENIRQ_EN
        dv0 = dv_cnt;
        frame(12'h123, 12'h456, 2, -1, -1, 1'b0, 1'b0, 1'b1);
        chk("penup_x_held", X_DATA, 12'h000);
        chk("penup_no_pulse", 12'(dv_cnt - dv0), 12'd0);
        frame(12'h123, 12'h456, 2, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("pendown_x", X_DATA, 12'h123);
        chk("pendown_pulse", 12'(dv_cnt - dv0), 12'd1);
`endif

        for (int n = 0; n < 30; n++) begin
            frame(12'($urandom), 12'($urandom), int'($urandom_range(1, 4)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 78)) : -1,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 78)) : -1,
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete within 2 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
